// File: rtl/lock_key_sequencer.sv
// Key loader and exhaustive pattern sweeper for the locked-circuit equivalence miter.
// Shifts in a serial key, walks every input pattern, and reports mismatches.
module lock_key_sequencer #(
    parameter int unsigned KEY_W = 10,
    parameter int unsigned IN_W  = 5,
    parameter int unsigned OUT_W = 2
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic             key_sin,
    input  logic             key_valid,
    input  logic [OUT_W-1:0] q_in,
    output logic [IN_W-1:0]  pat,
    output logic [KEY_W-1:0] lockingkey,
    output logic             busy,
    output logic             done,
    output logic             unlocked,
    output logic [IN_W:0]    err_cnt,
    output logic [IN_W-1:0]  first_fail
);

    localparam int unsigned KCW = $clog2(KEY_W + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StApply,
        StSample,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [KCW-1:0]    kcnt_q, kcnt_d;
    logic [IN_W-1:0]   pat_q, pat_d;
    logic [IN_W:0]     err_q, err_d;
    logic [IN_W-1:0]   ff_q, ff_d;
    logic              unl_q, unl_d;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= StIdle;
            key_q   <= '0;
            kcnt_q  <= '0;
            pat_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            unl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            kcnt_q  <= kcnt_d;
            pat_q   <= pat_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            unl_q   <= unl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        kcnt_d  = kcnt_q;
        pat_d   = pat_q;
        err_d   = err_q;
        ff_d    = ff_q;
        unl_d   = unl_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    key_d   = '0;
                    kcnt_d  = '0;
                    pat_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    unl_d   = 1'b0;
                end
            end
            StLoad: begin
                if (key_valid) begin
                    // LSB-first stream: first bit ends up at bit 0 after KEY_W shifts
                    key_d = {key_sin, key_q[KEY_W-1:1]};
                    if (kcnt_q == KCW'(KEY_W - 1)) begin
                        kcnt_d  = '0;
                        state_d = StApply;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            StApply: begin
                state_d = StSample;
            end
            StSample: begin
                if (!(&q_in)) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ff_d = pat_q;
                    end
                end
                if (pat_q == {IN_W{1'b1}}) begin
                    state_d = StDone;
                    // Uses the post-increment count so the verdict covers the last pattern
                    unl_d   = (err_d == '0);
                end else begin
                    pat_d   = pat_q + 1'b1;
                    state_d = StApply;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pat        = pat_q;
    assign lockingkey = key_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign unlocked   = unl_q;
    assign busy       = (state_q == StLoad) || (state_q == StApply) || (state_q == StSample);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Directed bench for lock_key_sequencer with a small behavioural miter model.
module tb_lock_key_sequencer;

    logic       C;
    logic       R;
    logic       start;
    logic       key_sin;
    logic       key_valid;
    logic [1:0] q_in;
    logic [4:0] pat;
    logic [9:0] lockingkey;
    logic       busy;
    logic       done;
    logic       unlocked;
    logic [5:0] err_cnt;
    logic [4:0] first_fail;

    int checks = 0;
    int errors = 0;
    int mode   = 0;  // 0: miter model, 1: stub failing at patterns 19 and 27
    logic [3:0] stall_pat = 4'b1001;

    lock_key_sequencer #(
        .KEY_W(10),
        .IN_W (5),
        .OUT_W(2)
    ) dut (
        .C         (C),
        .R         (R),
        .start     (start),
        .key_sin   (key_sin),
        .key_valid (key_valid),
        .q_in      (q_in),
        .pat       (pat),
        .lockingkey(lockingkey),
        .busy      (busy),
        .done      (done),
        .unlocked  (unlocked),
        .err_cnt   (err_cnt),
        .first_fail(first_fail)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    // Key bit 0 gates output 0, bits 1 and 2 together gate output 1
    always_comb begin
        if (mode == 1) begin
            q_in = (pat == 5'd19 || pat == 5'd27) ? 2'b01 : 2'b11;
        end else begin
            q_in = {lockingkey[1] & lockingkey[2], lockingkey[0]};
        end
    end

    task automatic do_run(input logic [9:0] key, input bit stall, input int poke,
                          input bit hold_done, input int exp_cycles, input logic [5:0] exp_err,
                          input logic [4:0] exp_ff, input logic exp_unl, input string name);
        int cyc     = 0;
        int nbit    = 0;
        bit busy_ok = 1'b1;
        bit got     = 1'b0;
        start = 1'b1;
        @(posedge C);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err_cnt !== 6'd0 || first_fail !== 5'd0 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b err_cnt=%0d first_fail=%0d unlocked=%b, need 1/0/0/0",
                     name, busy, err_cnt, first_fail, unlocked);
        end
        while (nbit < 10) begin
            key_valid = stall ? stall_pat[cyc % 4] : 1'b1;
            key_sin   = key[nbit];
            @(posedge C);
            cyc++;
            if (key_valid) nbit++;
            #1;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        key_valid = 1'b0;
        key_sin   = 1'b0;
        while (!got && cyc < 400) begin
            start = (cyc == poke);
            @(posedge C);
            cyc++;
            #1 start = 1'b0;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        checks++;
        if (!got || cyc != exp_cycles) begin
            errors++;
            $display("FAIL %s latency: done seen=%b after %0d cycles, need %0d", name, got, cyc,
                     exp_cycles);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: busy dropped during run, need continuously high", name);
        end
        checks++;
        if (err_cnt !== exp_err || first_fail !== exp_ff || unlocked !== exp_unl) begin
            errors++;
            $display("FAIL %s result: err_cnt=%0d first_fail=%0d unlocked=%b, need %0d/%0d/%b",
                     name, err_cnt, first_fail, unlocked, exp_err, exp_ff, exp_unl);
        end
        checks++;
        if (lockingkey !== key) begin
            errors++;
            $display("FAIL %s key: lockingkey=%h, need %h", name, lockingkey, key);
        end
        if (hold_done) start = 1'b1;
        @(posedge C);
        #1 start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== exp_err || unlocked !== exp_unl ||
            lockingkey !== key || pat !== 5'd31) begin
            errors++;
            $display("FAIL %s retain: done=%b busy=%b err_cnt=%0d unlocked=%b key=%h pat=%0d",
                     name, done, busy, err_cnt, unlocked, lockingkey, pat);
        end
        if (hold_done) begin
            @(posedge C);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_start: busy=%b done=%b, need 0/0", name, busy, done);
            end
        end
    endtask

    task automatic test_reset();
        R         = 1'b0;
        start     = 1'b0;
        key_sin   = 1'b0;
        key_valid = 1'b0;
        repeat (2) @(posedge C);
        #1;
        checks++;
        if (pat !== 5'd0 || lockingkey !== 10'd0 || busy !== 1'b0 || done !== 1'b0 ||
            unlocked !== 1'b0 || err_cnt !== 6'd0 || first_fail !== 5'd0) begin
            errors++;
            $display("FAIL reset: pat=%0d key=%h busy=%b done=%b unl=%b err=%0d ff=%0d, need all 0",
                     pat, lockingkey, busy, done, unlocked, err_cnt, first_fail);
        end
        @(negedge C);
        R = 1'b1;
        @(posedge C);
        #1;
    endtask

    task automatic test_correct_key();
        mode = 0;
        do_run(10'h007, 1'b0, -1, 1'b0, 74, 6'd0, 5'd0, 1'b1, "correct_key");
    endtask

    task automatic test_wrong_key();
        mode = 0;
        do_run(10'h006, 1'b0, -1, 1'b0, 74, 6'd32, 5'd0, 1'b0, "wrong_key");
    endtask

    task automatic test_key_stall();
        mode = 0;
        do_run(10'h3C7, 1'b1, -1, 1'b0, 84, 6'd0, 5'd0, 1'b1, "key_stall");
    endtask

    task automatic test_stub_miter();
        mode = 1;
        do_run(10'h2A5, 1'b0, -1, 1'b0, 74, 6'd2, 5'd19, 1'b0, "stub_miter");
    endtask

    task automatic test_start_ignored();
        mode = 1;
        do_run(10'h155, 1'b0, 14, 1'b1, 74, 6'd2, 5'd19, 1'b0, "start_ignored");
        mode = 0;
        do_run(10'h007, 1'b0, -1, 1'b0, 74, 6'd0, 5'd0, 1'b1, "rerun_after_ignore");
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] key = 10'h006;
        int         n   = 0;
        mode  = 0;
        start = 1'b1;
        @(posedge C);
        #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_valid = 1'b1;
            key_sin   = key[i];
            @(posedge C);
            #1;
        end
        key_valid = 1'b0;
        while (pat !== 5'd12 && n < 100) begin
            @(posedge C);
            #1;
            n++;
        end
        @(posedge C);
        #1;
        checks++;
        if (pat !== 5'd12 || err_cnt !== 6'd12 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_setup: pat=%0d err_cnt=%0d busy=%b, need 12/12/1", pat, err_cnt,
                     busy);
        end
        R = 1'b0;
        #1;
        checks++;
        if (pat !== 5'd0 || lockingkey !== 10'd0 || busy !== 1'b0 || done !== 1'b0 ||
            unlocked !== 1'b0 || err_cnt !== 6'd0 || first_fail !== 5'd0) begin
            errors++;
            $display("FAIL midrun_reset: pat=%0d key=%h busy=%b err=%0d ff=%0d, need all 0",
                     pat, lockingkey, busy, err_cnt, first_fail);
        end
        @(negedge C);
        R = 1'b1;
        @(posedge C);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: busy=%b done=%b, need 0/0", busy, done);
        end
        do_run(10'h007, 1'b0, -1, 1'b0, 74, 6'd0, 5'd0, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_correct_key();
        test_wrong_key();
        test_key_stall();
        test_stub_miter();
        test_start_ignored();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
